// File: rtl/param_ram_pkg.sv
// Shared types and defaults for the byte-enable parameter RAM.
package param_ram_pkg;

    // Controller states: CLEAR while sweeping zeros, IDLE while serving requests.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    localparam int DATA_W_DEFAULT = 32;
    localparam int DEPTH_DEFAULT  = 8;

    // Address width for a given depth, never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/param_ram_if.sv
// Request/response bundle between a requester (master) and the RAM (slave).
interface param_ram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic                  en;
    logic                  rw;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     in;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     out;
    logic                  rvalid;
    logic                  ready;
    logic                  err;

    modport master (
        output en, rw, address, in, be,
        input  out, rvalid, ready, err
    );

    modport slave (
        input  en, rw, address, in, be,
        output out, rvalid, ready, err
    );
endinterface

// File: rtl/param_ram_clr.sv
// Start-up controller: sweeps zeros through the array after reset, then
// raises ready. With CLEAR_ON_RESET=0 it goes straight to IDLE.
module param_ram_clr
    import param_ram_pkg::*;
#(
    parameter int DEPTH          = DEPTH_DEFAULT,
    parameter int CLEAR_ON_RESET = 1,
    parameter int ADDR_W         = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    localparam logic [0:0]        ST_CLEAR = CLEAR;
    localparam logic [0:0]        ST_IDLE  = IDLE;
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // Next state: step the sweep one word per cycle, leave after the last word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            if (CLEAR_ON_RESET == 0) begin
                state_d = ST_IDLE;
            end else if (cnt_q == LAST) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    // State and sweep counter; reset always restarts the sweep from word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready_o    = (state_q == ST_IDLE);
    assign clr_we_o   = (state_q == ST_CLEAR) && (CLEAR_ON_RESET != 0);
    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/param_ram.sv
// Single-port word RAM with byte-enable writes, registered 1-cycle reads,
// out-of-range error pulse and an optional zero-fill sweep after reset.
module param_ram
    import param_ram_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEFAULT,
    parameter int DEPTH          = DEPTH_DEFAULT,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    param_ram_if.slave bus
);

    localparam int              ADDR_W  = addr_width(DEPTH);
    localparam int              NBYTES  = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              ready;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              acc;
    logic              in_range;
    logic              wr_ok;
    logic              rd_ok;
    logic [ADDR_W-1:0] idx;

    logic [DATA_W-1:0] out_q, out_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;

    param_ram_clr #(
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET),
        .ADDR_W         (ADDR_W)
    ) u_clr (
        .clk        (clk),
        .rst_n      (rst_n),
        .ready_o    (ready),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    // Request decode; the index is forced in range so the array is never
    // addressed past DEPTH-1 when DEPTH is not a power of two.
    assign acc      = bus.en & ready;
    assign in_range = ({1'b0, bus.address} < DEPTH_C);
    assign wr_ok    = acc &  bus.rw & in_range;
    assign rd_ok    = acc & ~bus.rw & in_range;
    assign idx      = in_range ? bus.address : '0;

    // Read path next-state: out only moves on an accepted in-range read.
    always_comb begin
        out_d    = out_q;
        rvalid_d = rd_ok;
        err_d    = acc & ~in_range;
        if (rd_ok) begin
            out_d = mem_q[idx];
        end
    end

    // Array write port: the sweep owns it while clearing, else byte-enabled writes.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_ok) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (bus.be[k]) begin
                    mem_q[idx][8*k +: 8] <= bus.in[8*k +: 8];
                end
            end
        end
    end

    // Registered read data and the one-cycle rvalid/err pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            out_q    <= out_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign bus.out    = out_q;
    assign bus.rvalid = rvalid_q;
    assign bus.ready  = ready;
    assign bus.err    = err_q;

endmodule
